// File: rtl/ysyx_24100027_pkg.sv
// Shared definitions for the ysyx_24100027 core: fetch FSM encoding,
// default reset PC and the RISC-V instruction field positions that the
// decode stage slices with the same constants.
package ysyx_24100027_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // RISC-V base instruction field positions
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } ifu_state_t;

  // A fetch address is legal only when it is word aligned.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_24100027_ifu_if.sv
// Instruction-memory port: one request channel (valid/ready + address)
// and one response channel (valid + data + error). The fetch unit is the
// master; the memory is the slave.
interface ysyx_24100027_ifu_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            imem_resp_err;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  imem_resp_err
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output imem_resp_err
  );
endinterface

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit of the ysyx_24100027 multi-cycle core. Owns the
// PC, issues one word fetch per instruction, holds the fetched word for
// decode and waits for the commit carrying the next PC. No prefetch.
// Every output is a register or a slice of one, so no input reaches an
// output combinationally.
module ysyx_24100027_ifu
  import ysyx_24100027_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_24100027_ifu_if.master imem,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [XLEN-1:0]     pc,
  input  logic                commit_valid,
  input  logic [XLEN-1:0]     commit_pc,
  output logic                fetch_fault,
  output logic [31:0]         fetch_cnt
);

  ifu_state_t      state_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     inst_r;
  logic [31:0]     fetch_cnt_r;
  logic            req_valid_r;
  logic            inst_valid_r;
  logic            fault_r;

  // Fetch FSM with PC, instruction register, counter and registered flags.
  // req_valid_r is raised together with entry into S_REQ, but only for an
  // aligned PC, so a misaligned target never shows a request pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      fetch_cnt_r  <= 32'h0000_0000;
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r     <= S_REQ;
          req_valid_r <= is_word_aligned(pc_r[1:0]);
        end
        S_REQ: begin
          if (!is_word_aligned(pc_r[1:0])) begin
            state_r     <= S_FAULT;
            req_valid_r <= 1'b0;
            fault_r     <= 1'b1;
          end else if (imem.imem_req_ready) begin
            state_r     <= S_RESP;
            req_valid_r <= 1'b0;
          end else begin
            state_r     <= S_REQ;
          end
        end
        S_RESP: begin
          if (imem.imem_resp_valid) begin
            if (imem.imem_resp_err) begin
              state_r <= S_FAULT;
              fault_r <= 1'b1;
            end else begin
              state_r      <= S_HOLD;
              inst_r       <= imem.imem_resp_data;
              fetch_cnt_r  <= fetch_cnt_r + 32'd1;
              inst_valid_r <= 1'b1;
            end
          end else begin
            state_r <= S_RESP;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_r <= 1'b0;
            if (commit_valid) begin
              // single-cycle downstream: skip S_EXEC entirely
              state_r     <= S_REQ;
              pc_r        <= commit_pc;
              req_valid_r <= is_word_aligned(commit_pc[1:0]);
            end else begin
              state_r <= S_EXEC;
            end
          end else begin
            state_r <= S_HOLD;
          end
        end
        S_EXEC: begin
          if (commit_valid) begin
            state_r     <= S_REQ;
            pc_r        <= commit_pc;
            req_valid_r <= is_word_aligned(commit_pc[1:0]);
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_FAULT: begin
          state_r <= S_FAULT;
        end
        default: begin
          // unreachable encoding: park safely in the fault state
          state_r      <= S_FAULT;
          req_valid_r  <= 1'b0;
          inst_valid_r <= 1'b0;
          fault_r      <= 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req_valid = req_valid_r;
  assign imem.imem_req_addr  = pc_r;
  assign inst_valid          = inst_valid_r;
  assign inst                = inst_r;
  assign opcode              = inst_r[OPCODE_MSB:OPCODE_LSB];
  assign funct3              = inst_r[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7              = inst_r[FUNCT7_MSB:FUNCT7_LSB];
  assign pc                  = pc_r;
  assign fetch_fault         = fault_r;
  assign fetch_cnt           = fetch_cnt_r;

endmodule
